hex_scan_controller: RTL and testbench

Bus-mapped controller that owns an 8-digit multiplexed seven-segment display. It holds one hex nibble per digit, written by the CPU over the chip-select/write strobe bus. A prescaled scan FSM time-shares a single hex-to-segment decoder across all digits. Each slot is followed by a dead-time blank to suppress ghosting. It sits between the system bus and the board's shared segment and common-anode pins.

---
 rtl/hex_pkg.sv | 15 +
 rtl/hex_scan_controller_if.sv | 24 ++
 rtl/hex_seg_lut.sv | 27 ++
 rtl/hex_scan_controller.sv | 153 +++++++++++++++
 tb/tb_hex_scan_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package hex_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_PACKED = 4'd9;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MASK_LSB = 8;
    localparam int unsigned CTRL_MASK_MSB = 15;

endpackage

// File: rtl/hex_scan_controller_if.sv
// Bus and display pin bundle: CPU strobe bus in, segment/digit pins out.
interface hex_scan_controller_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                  iChip_select_n;
    logic                  iWrite_n;
    logic                  iRead_n;
    logic [3:0]            iAddr;
    logic [31:0]           iData;
    logic [31:0]           oData;
    logic [6:0]            oSeg;
    logic [NUM_DIGITS-1:0] oDigit_n;
    logic [2:0]            oScan_idx;

    modport master (
        output iChip_select_n, iWrite_n, iRead_n, iAddr, iData,
        input  oData, oSeg, oDigit_n, oScan_idx
    );

    modport slave (
        input  iChip_select_n, iWrite_n, iRead_n, iAddr, iData,
        output oData, oSeg, oDigit_n, oScan_idx
    );
endinterface

// File: rtl/hex_seg_lut.sv
// Hex nibble to active-low seven-segment pattern, bit0=a .. bit6=g.
module hex_seg_lut (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        unique case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/hex_scan_controller.sv
// Bus-mapped 8-digit hex display controller: register file plus prescaled scan FSM
// sharing one segment decoder across all digits, with dead-time blanking between slots.
module hex_scan_controller
    import hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input logic                  iClk,
    input logic                  iReset,
    hex_scan_controller_if.slave bus
);
    localparam int unsigned CNT_MAX = (TICK_DIV > DEAD_CYCLES) ? TICK_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] NUM_ADDR = 4'(NUM_DIGITS);

    logic [3:0]            r_digit [NUM_DIGITS];
    logic                  r_en;
    logic [7:0]            r_mask;
    scan_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_idx;

    logic                  w_rd;
    logic                  w_wr;
    logic [31:0]           w_packed;
    logic [31:0]           w_rd_data;
    logic [2:0]            w_idx_inc;
    logic [2:0]            w_lut_idx;
    logic                  w_slot_end;
    logic [6:0]            w_seg;
    logic [6:0]            w_show_seg;
    logic [NUM_DIGITS-1:0] w_show_dig;

    assign w_rd = !bus.iChip_select_n && !bus.iRead_n;
    assign w_wr = !bus.iChip_select_n && !bus.iWrite_n;

    always_comb begin
        w_packed = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_packed[4*k +: 4] = r_digit[k];
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (bus.iAddr < NUM_ADDR) begin
            w_rd_data = {28'd0, r_digit[bus.iAddr[2:0]]};
        end else if (bus.iAddr == ADDR_CTRL) begin
            w_rd_data = {16'd0, r_mask, 7'd0, r_en};
        end else if (bus.iAddr == ADDR_PACKED) begin
            w_rd_data = w_packed;
        end
    end

    // Reads sample the registers before this edge's write, so read-during-write sees old data.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= 4'd0;
            r_en     <= 1'b0;
            r_mask   <= 8'd0;
            bus.oData <= 32'd0;
        end else begin
            if (w_rd) bus.oData <= w_rd_data;
            if (w_wr) begin
                if (bus.iAddr < NUM_ADDR) begin
                    r_digit[bus.iAddr[2:0]] <= bus.iData[3:0];
                end else if (bus.iAddr == ADDR_CTRL) begin
                    r_en   <= bus.iData[CTRL_EN_BIT];
                    r_mask <= bus.iData[CTRL_MASK_MSB:CTRL_MASK_LSB];
                end else if (bus.iAddr == ADDR_PACKED) begin
                    for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= bus.iData[4*k +: 4];
                end
            end
        end
    end

    // Decoder is fed the digit that will be lit after this edge, so outputs stay registered.
    assign w_idx_inc  = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    assign w_slot_end = (r_state == SHOW) && (r_cnt == TICK_LAST);
    assign w_lut_idx  = ((r_state == BLANK) || (w_slot_end && DEAD_CYCLES == 0)) ? w_idx_inc
                                                                                 : r_idx;
    assign w_show_seg = r_mask[w_lut_idx] ? SEG_BLANK : w_seg;
    assign w_show_dig = r_mask[w_lut_idx] ? '1 : ~(NUM_DIGITS'(1) << w_lut_idx);
    assign bus.oScan_idx = r_idx;

    hex_seg_lut u_seg_lut (
        .i_nibble (r_digit[w_lut_idx]),
        .o_seg    (w_seg)
    );

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            bus.oSeg     <= SEG_BLANK;
            bus.oDigit_n <= '1;
        end else if (!r_en) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            bus.oSeg     <= SEG_BLANK;
            bus.oDigit_n <= '1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state      <= SHOW;
                    r_cnt        <= '0;
                    r_idx        <= 3'd0;
                    bus.oSeg     <= w_show_seg;
                    bus.oDigit_n <= w_show_dig;
                end
                SHOW: begin
                    if (w_slot_end) begin
                        r_cnt <= '0;
                        if (DEAD_CYCLES == 0) begin
                            r_idx        <= w_idx_inc;
                            bus.oSeg     <= w_show_seg;
                            bus.oDigit_n <= w_show_dig;
                        end else begin
                            r_state      <= BLANK;
                            bus.oSeg     <= SEG_BLANK;
                            bus.oDigit_n <= '1;
                        end
                    end else begin
                        r_cnt        <= r_cnt + 1'b1;
                        bus.oSeg     <= w_show_seg;
                        bus.oDigit_n <= w_show_dig;
                    end
                end
                BLANK: begin
                    if (r_cnt == DEAD_LAST) begin
                        r_state      <= SHOW;
                        r_cnt        <= '0;
                        r_idx        <= w_idx_inc;
                        bus.oSeg     <= w_show_seg;
                        bus.oDigit_n <= w_show_dig;
                    end else begin
                        r_cnt        <= r_cnt + 1'b1;
                        bus.oSeg     <= SEG_BLANK;
                        bus.oDigit_n <= '1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_scan_controller.sv
// Scoreboard bench for hex_scan_controller: stimulus pushes expected read data and per-cycle
// display state; a negedge monitor pops and compares.
module tb_hex_scan_controller;
    import hex_pkg::*;

    localparam int ND = 8;
    localparam int TD = 4;
    localparam int DC = 2;
    localparam int SLOT = TD + DC;
    localparam int PERIOD = ND * SLOT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

    hex_scan_controller #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .DEAD_CYCLES (DC)
    ) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic [31:0] care;
        string       name;
    } exp_t;

    exp_t rd_q[$];
    exp_t disp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   end_cyc = -1;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [3:0] sh_digit [ND];
    logic       sh_en;
    logic [7:0] sh_mask;
    int         en_edge;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected {idx, digit_n, seg} after edge c; scan index is don't-care in dead time.
    function automatic void disp_model(input int c, output logic [31:0] v,
                                       output logic [31:0] care);
        int t, pos, slot, off;
        v = {14'd0, 3'd0, 8'hFF, 7'h7F};
        care = 32'hFFFFFFFF;
        if (sh_en) begin
            t = c - en_edge;
            pos = (t - 1) % PERIOD;
            slot = pos / SLOT;
            off = pos % SLOT;
            if (off < TD) begin
                v[17:15] = 3'(slot);
                if (!sh_mask[slot]) begin
                    v[14:7] = ~(8'd1 << slot);
                    v[6:0] = seg_tab[sh_digit[slot]];
                end
            end else begin
                care = 32'h00007FFF;
            end
        end
    endfunction

    function automatic void apply_write(input logic [3:0] a, input logic [31:0] d, input int c);
        if (a < 4'd8) begin
            sh_digit[a[2:0]] = d[3:0];
        end else if (a == 4'd8) begin
            if (!sh_en && d[0]) en_edge = c;
            sh_en = d[0];
            sh_mask = d[15:8];
        end else if (a == 4'd9) begin
            for (int k = 0; k < ND; k++) sh_digit[k] = d[4*k +: 4];
        end
    endfunction

    task automatic tick(input bit wr, input bit rd, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string nm);
        logic [31:0] v, care;
        bus.iChip_select_n = !(wr || rd);
        bus.iWrite_n = !wr;
        bus.iRead_n = !rd;
        bus.iAddr = a;
        bus.iData = d;
        @(posedge clk);
        #1;
        disp_model(cyc, v, care);
        disp_q.push_back('{cyc, v, care, {"disp_", nm}});
        if (rd) rd_q.push_back('{cyc, exp_rd, 32'hFFFFFFFF, nm});
        if (wr) apply_write(a, d, cyc);
        bus.iChip_select_n = 1'b1;
        bus.iWrite_n = 1'b1;
        bus.iRead_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, "idle");
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (disp_q.size() > 0 && disp_q[0].cyc <= cyc) begin
            e = disp_q.pop_front();
            got = {14'd0, bus.oScan_idx, bus.oDigit_n, bus.oSeg};
            checks++;
            if (e.cyc != cyc || ((got ^ e.val) & e.care) != 0) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h expected=%h care=%h", e.name, e.cyc, got,
                         e.val, e.care);
            end
        end
        while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            e = rd_q.pop_front();
            checks++;
            if (e.cyc != cyc || bus.oData !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d oData got=%h expected=%h", e.name, e.cyc, bus.oData,
                         e.val);
            end
        end
        if (cyc == end_cyc) begin
            checks++;
            if (disp_q.size() != 0 || rd_q.size() != 0) begin
                errors++;
                $display("FAIL leftover disp=%0d rd=%0d expected 0", disp_q.size(), rd_q.size());
            end
        end
    end

    initial begin
        logic [31:0] rv, rc;
        rst = 1'b1;
        bus.iChip_select_n = 1'b1;
        bus.iWrite_n = 1'b1;
        bus.iRead_n = 1'b1;
        bus.iAddr = 4'd0;
        bus.iData = 32'd0;
        for (int k = 0; k < ND; k++) sh_digit[k] = 4'd0;
        sh_en = 1'b0;
        sh_mask = 8'd0;
        en_edge = 0;

        idle(1);
        rd_q.push_back('{cyc, 32'd0, 32'hFFFFFFFF, "rst_odata"});
        idle(2);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) tick(1'b0, 1'b1, 4'(a), 32'd0, 32'd0, "rd_after_reset");
        idle(5);

        tick(1'b1, 1'b0, 4'd9, 32'h76543210, 32'd0, "wr_packed");
        tick(1'b0, 1'b1, 4'd9, 32'd0, 32'h76543210, "rd_packed");
        tick(1'b0, 1'b1, 4'd2, 32'd0, 32'h00000002, "rd_digit2");
        tick(1'b1, 1'b0, 4'd8, 32'h00000001, 32'd0, "wr_ctrl_en");
        idle(100);

        tick(1'b1, 1'b0, 4'd8, 32'h00000401, 32'd0, "wr_ctrl_mask2");
        tick(1'b0, 1'b1, 4'd8, 32'd0, 32'h00000401, "rd_ctrl");
        idle(60);

        // Land the digit-3 write on the first lit cycle of slot 3.
        for (int i = 0; i < PERIOD; i++) begin
            if ((cyc - en_edge) % PERIOD == 3 * SLOT) break;
            idle(1);
        end
        tick(1'b1, 1'b0, 4'd3, 32'h0000000E, 32'd0, "wr_digit3_live");
        idle(20);

        for (int i = 0; i < SLOT; i++) begin
            if ((cyc - en_edge) % SLOT == 1) break;
            idle(1);
        end
        tick(1'b1, 1'b0, 4'd8, 32'h00000000, 32'd0, "wr_ctrl_off");
        idle(5);
        tick(1'b1, 1'b0, 4'd8, 32'h00000001, 32'd0, "wr_ctrl_reen");
        idle(20);

        tick(1'b1, 1'b0, 4'd12, 32'h00000005, 32'd0, "wr_addr12");
        tick(1'b0, 1'b1, 4'd12, 32'd0, 32'd0, "rd_addr12");
        tick(1'b0, 1'b1, 4'd9, 32'd0, 32'h7654E210, "rd_packed2");
        tick(1'b0, 1'b1, 4'd8, 32'd0, 32'h00000001, "rd_ctrl2");
        tick(1'b1, 1'b1, 4'd1, 32'h00000009, 32'h00000001, "rdwr_same_addr");
        tick(1'b0, 1'b1, 4'd1, 32'd0, 32'h00000009, "rd_digit1_new");
        idle(10);

        // Asynchronous reset mid-scan: outputs must clear before the next edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        disp_model(-1, rv, rc);
        rv = {14'd0, 3'd0, 8'hFF, 7'h7F};
        disp_q.push_back('{cyc, rv, 32'hFFFFFFFF, "disp_async_reset"});
        rd_q.push_back('{cyc, 32'd0, 32'hFFFFFFFF, "odata_async_reset"});
        for (int k = 0; k < ND; k++) sh_digit[k] = 4'd0;
        sh_en = 1'b0;
        sh_mask = 8'd0;
        idle(2);
        rst = 1'b0;
        tick(1'b0, 1'b1, 4'd9, 32'd0, 32'd0, "rd_packed_after_rst");
        tick(1'b0, 1'b1, 4'd8, 32'd0, 32'd0, "rd_ctrl_after_rst");
        idle(3);

        end_cyc = cyc + 1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
